// File: rtl/state_trace_logger_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : trace_pkg                                                      |
// | Shared types and constants for the state trace logger.                   |
// | Provides the controller state enumeration, the default entry layout      |
// | {timestamp, state} and the width of the drop counter.                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package trace_pkg;

    localparam int TRACE_STATE_W = 3;
    localparam int TRACE_TS_W    = 32;
    localparam int TRACE_DEPTH   = 16;
    localparam int DROP_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } trace_st_t;

    typedef struct packed {
        logic [TRACE_TS_W-1:0]    ts;
        logic [TRACE_STATE_W-1:0] state;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/state_trace_logger_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : state_trace_logger_if                                        |
// | Read-side valid/ready port of the state trace logger.                    |
// |   rd_valid : head entry available          (master -> slave)             |
// |   rd_ready : reader accepts head entry     (slave  -> master)            |
// |   rd_state : head entry state              (master -> slave)             |
// |   rd_ts    : head entry timestamp          (master -> slave)             |
// | Modports: master = logger side, slave = reader side.                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface state_trace_logger_if
    import trace_pkg::*;
#(
    parameter int STATE_W = TRACE_STATE_W,
    parameter int TS_W    = TRACE_TS_W
);
    logic               rd_valid;
    logic               rd_ready;
    logic [STATE_W-1:0] rd_state;
    logic [TS_W-1:0]    rd_ts;

    modport master (
        output rd_valid,
        output rd_state,
        output rd_ts,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_state,
        input  rd_ts,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/state_trace_logger_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : trace_fifo                                                     |
// | Synchronous FIFO with a registered head word.                            |
// |   clock/reset : rising-edge clock, synchronous active-high reset         |
// |   i_flush     : synchronous flush, empties the FIFO                      |
// |   i_push      : write request, accepted if not full or popping           |
// |   i_data      : write data                                               |
// |   i_ready     : reader accepts the head word                             |
// |   o_valid     : head word available                                      |
// |   o_data      : registered head word, zero while empty                   |
// |   o_full      : FIFO holds DEPTH words                                   |
// |   o_level     : occupancy, 0..DEPTH                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module trace_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [c_AW:0]    w_wptr_nxt;
    logic [c_AW:0]    w_rptr_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                        (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop      = !w_empty && i_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    assign w_push     = i_push && (!w_full || w_pop);
    assign w_wptr_nxt = r_wptr + {{c_AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{c_AW{1'b0}}, w_pop};

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_head <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            // The head register tracks whatever sits at the next read pointer.
            // If that slot is being written this very cycle, take the write data.
            if (w_wptr_nxt == w_rptr_nxt) begin
                r_head <= '0;
            end else if (w_push && (w_rptr_nxt == r_wptr)) begin
                r_head <= i_data;
            end else begin
                r_head <= r_mem[w_rptr_nxt[c_AW-1:0]];
            end
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = r_head;
    assign o_full  = w_full;
    assign o_level = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/state_trace_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : state_trace_logger                                             |
// | Watches an FSM state vector and logs {timestamp, state} into a FIFO on   |
// | every state change while running.                                        |
// |   clock, reset : rising-edge clock, synchronous active-high reset        |
// |   enable       : 1 = capture, 0 = back to idle (FIFO contents kept)      |
// |   clear        : synchronous flush of FIFO, flags and counters           |
// |   state_in     : observed state vector                                   |
// |   rd           : valid/ready read port (master modport)                  |
// |   level        : FIFO occupancy                                          |
// |   overflow     : sticky, at least one event dropped                      |
// |   drop_cnt     : dropped events, saturating                              |
// |   ts_wrap      : sticky, timestamp counter wrapped                       |
// |   stop_cycle   : stop compare value       (TRACE_STOP_EN only)           |
// |   stopped      : capture frozen           (TRACE_STOP_EN only)           |
// | Build option: define TRACE_STOP_EN to add the stop-on-timestamp feature. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module state_trace_logger
    import trace_pkg::*;
#(
    parameter int STATE_W = TRACE_STATE_W,
    parameter int TS_W    = TRACE_TS_W,
    parameter int DEPTH   = TRACE_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [STATE_W-1:0]      state_in,
    state_trace_logger_if.master    rd,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic                    ts_wrap
`ifdef TRACE_STOP_EN
    ,
    input  logic [TS_W-1:0]         stop_cycle,
    output logic                    stopped
`endif
);
    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_RUN  = RUN;
`ifdef TRACE_STOP_EN
    localparam logic [1:0] c_ST_DONE = DONE;
`endif

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [STATE_W-1:0] state;
    } entry_t;

    logic [1:0]            r_fsm;
    logic [TS_W-1:0]       r_ts;
    logic [STATE_W-1:0]    r_prev_state;
    logic                  r_prev_valid;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_ts_wrap;
`ifdef TRACE_STOP_EN
    logic                  r_stopped;
`endif

    logic                  w_event;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_valid;
    entry_t                w_push_entry;
    entry_t                w_head;

    // The first running cycle always logs because prev_valid starts cleared.
    assign w_event = (r_fsm == c_ST_RUN) && enable &&
                     (!r_prev_valid || (state_in != r_prev_state));
    assign w_pop   = w_valid && rd.rd_ready;
    assign w_drop  = w_event && w_full && !w_pop;

    assign w_push_entry.ts    = r_ts;
    assign w_push_entry.state = state_in;

    trace_fifo #(
        .WIDTH (TS_W + STATE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (clear),
        .i_push  (w_event),
        .i_data  (w_push_entry),
        .i_ready (rd.rd_ready),
        .o_valid (w_valid),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_level (level)
    );

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_fsm        <= c_ST_IDLE;
            r_ts         <= '0;
            r_prev_state <= '0;
            r_prev_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_ts_wrap    <= 1'b0;
`ifdef TRACE_STOP_EN
            r_stopped    <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_fsm        <= c_ST_RUN;
                        r_ts         <= '0;
                        r_prev_valid <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (!enable) begin
                        r_fsm <= c_ST_IDLE;
                    end else begin
                        r_ts <= r_ts + TS_W'(1);
                        if (&r_ts) begin
                            r_ts_wrap <= 1'b1;
                        end
                        // Dropped events still update the reference state.
                        if (w_event) begin
                            r_prev_state <= state_in;
                            r_prev_valid <= 1'b1;
                        end
`ifdef TRACE_STOP_EN
                        if (r_ts == stop_cycle) begin
                            r_fsm     <= c_ST_DONE;
                            r_stopped <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    // DONE is left only through clear or reset.
                end
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign rd.rd_valid = w_valid;
    assign rd.rd_state = w_head.state;
    assign rd.rd_ts    = w_head.ts;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;
    assign ts_wrap     = r_ts_wrap;
`ifdef TRACE_STOP_EN
    assign stopped     = r_stopped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_state_trace_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_state_trace_logger                                          |
// | Self-checking bench for state_trace_logger: directed scenarios followed  |
// | by random stimulus, all compared against a queue-based reference model.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_state_trace_logger;
    localparam int STATE_W = 3;
    localparam int TS_W    = 4;
    localparam int DEPTH   = 4;

    logic               clock;
    logic               reset;
    logic               enable;
    logic               clear;
    logic [STATE_W-1:0] state_in;
    logic [2:0]         level;
    logic               overflow;
    logic [7:0]         drop_cnt;
    logic               ts_wrap;
`ifdef TRACE_STOP_EN
    logic [TS_W-1:0]    stop_cycle;
    logic               stopped;
`endif

    state_trace_logger_if #(.STATE_W(STATE_W), .TS_W(TS_W)) rd_if ();

    state_trace_logger #(
        .STATE_W (STATE_W),
        .TS_W    (TS_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .state_in   (state_in),
        .rd         (rd_if),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .ts_wrap    (ts_wrap)
`ifdef TRACE_STOP_EN
        ,
        .stop_cycle (stop_cycle),
        .stopped    (stopped)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a queue of logged entries plus run/stop bookkeeping.
    typedef struct {
        int ts;
        int st;
    } ent_t;

    ent_t mq[$];
    bit   m_run, m_done, m_have, m_ovf, m_wrap, m_stop;
    int   m_ts, m_prev, m_drops;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit pop, ev;
        int ts_old;
        if (reset || clear) begin
            mq.delete();
            m_run = 0; m_done = 0; m_have = 0; m_ovf = 0; m_wrap = 0; m_stop = 0;
            m_ts = 0; m_prev = 0; m_drops = 0;
            return;
        end
        pop = (mq.size() != 0) && rd_if.rd_ready;
        ev  = m_run && enable && (!m_have || int'(state_in) != m_prev);
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() < DEPTH) mq.push_back('{ts: m_ts, st: int'(state_in)});
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            m_prev = int'(state_in);
            m_have = 1;
        end
        if (m_run) begin
            if (!enable) m_run = 0;
            else begin
                ts_old = m_ts;
                m_ts = (m_ts + 1) % (1 << TS_W);
                if (m_ts == 0) m_wrap = 1;
`ifdef TRACE_STOP_EN
                if (ts_old == int'(stop_cycle)) begin
                    m_run = 0; m_done = 1; m_stop = 1;
                end
`else
                ts_old = ts_old;
`endif
            end
        end else if (!m_done && enable) begin
            m_run = 1; m_ts = 0; m_have = 0;
        end
    endtask

    task automatic compare_all();
        check("rd_valid", rd_if.rd_valid, mq.size() != 0);
        check("rd_state", rd_if.rd_state, (mq.size() != 0) ? mq[0].st : 0);
        check("rd_ts",    rd_if.rd_ts,    (mq.size() != 0) ? mq[0].ts : 0);
        check("level",    level,          mq.size());
        check("overflow", overflow,       m_ovf);
        check("drop_cnt", drop_cnt,       m_drops);
        check("ts_wrap",  ts_wrap,        m_wrap);
`ifdef TRACE_STOP_EN
        check("stopped",  stopped,        m_stop);
`endif
    endtask

    // One clock: advance the model with the current inputs, then sample.
    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    initial begin
        int exp_ts[4];
        int exp_st[4];
        exp_ts = '{1, 2, 3, 7};
        exp_st = '{1, 0, 1, 1};

        reset = 1'b1; clear = 1'b0; enable = 1'b0; state_in = '0; rd_if.rd_ready = 1'b0;
`ifdef TRACE_STOP_EN
        stop_cycle = '1;
`endif
        cyc();
        reset = 1'b0;
        check("reset_level", level, 0);
        check("reset_valid", rd_if.rd_valid, 0);

        // Two entries: first running cycle, then the change at ts=5.
        enable = 1'b1;
        cyc();
        repeat (5) cyc();
        state_in = 3'd1;
        cyc();
        check("t1_level", level, 2);
        check("t1_head_ts", rd_if.rd_ts, 0);
        check("t1_head_st", rd_if.rd_state, 0);
        enable = 1'b0; rd_if.rd_ready = 1'b1;
        cyc();
        check("t1_second_ts", rd_if.rd_ts, 5);
        check("t1_second_st", rd_if.rd_state, 1);
        cyc();
        check("t1_empty", rd_if.rd_valid, 0);
        rd_if.rd_ready = 1'b0;

        // Overflow: seven events into four slots.
        clear = 1'b1; cyc(); clear = 1'b0;
        enable = 1'b1; state_in = 3'd0;
        cyc();
        cyc();
        for (int i = 1; i <= 6; i++) begin
            state_in = STATE_W'(i % 2);
            cyc();
        end
        check("t2_level", level, 4);
        check("t2_overflow", overflow, 1);
        check("t2_drop_cnt", drop_cnt, 3);

        // Full FIFO, pop and event in the same cycle.
        state_in = 3'd1; rd_if.rd_ready = 1'b1;
        cyc();
        check("t3_level", level, 4);
        check("t3_drop_cnt", drop_cnt, 3);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t3_order_ts", rd_if.rd_ts, exp_ts[k]);
            check("t3_order_st", rd_if.rd_state, exp_st[k]);
            cyc();
        end
        check("t3_drained", rd_if.rd_valid, 0);
        rd_if.rd_ready = 1'b0;

        // Timestamp wrap with a 4-bit counter.
        clear = 1'b1; cyc(); clear = 1'b0;
        enable = 1'b1; state_in = 3'd2;
        cyc();
        repeat (20) cyc();
        state_in = 3'd5;
        cyc();
        check("t4_wrap", ts_wrap, 1);
        check("t4_level", level, 2);
        enable = 1'b0; rd_if.rd_ready = 1'b1;
        cyc();
        check("t4_second_ts", rd_if.rd_ts, 4);
        check("t4_second_st", rd_if.rd_state, 5);
        cyc();
        rd_if.rd_ready = 1'b0;

`ifdef TRACE_STOP_EN
        clear = 1'b1; cyc(); clear = 1'b0;
        stop_cycle = 4'd10; enable = 1'b1; state_in = 3'd0;
        cyc();
        for (int t = 0; t < 14; t++) begin
            state_in = (t >= 12) ? 3'd2 : ((t >= 3) ? 3'd1 : 3'd0);
            cyc();
            if (t == 9)  check("t5_not_stopped", stopped, 0);
            if (t == 10) check("t5_stopped", stopped, 1);
        end
        check("t5_level", level, 2);
        check("t5_head_ts", rd_if.rd_ts, 0);
        stop_cycle = '1;
`endif

        // Clear during a read handshake with three entries queued.
        clear = 1'b1; cyc(); clear = 1'b0;
        enable = 1'b1; state_in = 3'd0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            state_in = STATE_W'(i);
            cyc();
        end
        check("t6_level_before", level, 3);
        rd_if.rd_ready = 1'b1; clear = 1'b1;
        cyc();
        clear = 1'b0; rd_if.rd_ready = 1'b0;
        check("t6_level", level, 0);
        check("t6_valid", rd_if.rd_valid, 0);
        check("t6_overflow", overflow, 0);
        cyc();
        check("t6_idle_level", level, 0);
        cyc();
        check("t6_restart_level", level, 1);
        check("t6_restart_ts", rd_if.rd_ts, 0);

        // Drop counter saturation.
        clear = 1'b1; cyc(); clear = 1'b0;
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 270; i++) begin
            state_in = STATE_W'(i % 2);
            cyc();
        end
        check("sat_drop_cnt", drop_cnt, 255);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0) state_in = STATE_W'($urandom_range(0, 7));
            rd_if.rd_ready = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 199) == 0);
`ifdef TRACE_STOP_EN
            if ($urandom_range(0, 49) == 0) stop_cycle = TS_W'($urandom_range(0, 15));
`endif
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
